uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered asynchronous serial transmitter driving the board UART TXD pin. It is the transmit counterpart of the UART receive path.
- It takes parallel bytes from core logic (e.g. random values from the top-level game core, converted to ASCII upstream) via a valid/ready push interface.
- Bytes are queued in a small FIFO and serialized as standard start/data/stop frames, LSB first, at a fixed baud rate.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, truncated; 434 at defaults), clock cycles per serial bit; must be >= 2
- DATA_BITS, 8, payload bits per frame, legal range 5..8
- STOP_BITS, 1, stop bits per frame, legal values 1 or 2
- DEPTH, 4, FIFO entries, power of two, >= 2

Ports:
- i_clk  input  1  system clock, rising-edge active
- i_rst  input  1  synchronous, active-high reset
- i_data  input  DATA_BITS  byte to transmit
- i_valid  input  1  push request; a push is accepted on an edge where i_valid && o_ready
- o_ready  output  1  FIFO not full; combinational from the FIFO count
- o_txd  output  1  serial line, registered, idle high
- o_busy  output  1  high while a frame is on the line or the FIFO is non-empty
- o_done  output  1  one-cycle pulse on the last cycle of each frame's final stop bit
- o_overflow  output  1  sticky flag; set when i_valid is high while o_ready is low

Behaviour:
- Reset (synchronous, i_rst=1 at an edge):
  - outputs after that edge: o_txd=1, o_busy=0, o_done=0, o_overflow=0, o_ready=1
  - FIFO flushed; FSM forced to IDLE; bit and baud counters cleared
- Reset mid-frame: the frame is aborted and o_txd returns high on the reset edge. No partial stop bit; the queued bytes are lost.
- FSM states: IDLE, START, DATA, PARITY (optional feature only), STOP.
  - IDLE: o_txd=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: o_txd=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: output shift[0], LSB first, for CLKS_PER_BIT cycles per bit, over DATA_BITS bits. Then go to PARITY if the feature is enabled, else STOP.
  - PARITY: o_txd=parity bit for CLKS_PER_BIT cycles, then STOP.
  - STOP: o_txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - o_done is pulsed on the final cycle of STOP.
    - If the FIFO is non-empty on that cycle, pop it and go directly to START; otherwise go to IDLE.
- Frame timing:
  - Exact frame length is (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
  - Back-to-back frames are contiguous, with no idle gap.
- Latency: with the FSM in IDLE and the FIFO empty, a push accepted at edge N makes o_txd fall at edge N+2.
- FIFO rules:
  - Push when full: the entry is dropped, the contents are unchanged, and o_overflow is set.
  - Push and pop on the same edge: both occur and the count is unchanged.
  - When full, o_ready stays low even if a pop occurs on that edge; there is no full-bypass.
  - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - The count is log2(DEPTH)+1 bits wide, with range 0..DEPTH.
- o_busy = (state != IDLE) || (count != 0).
- o_overflow clears only on reset.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- Defined:
  - a PARITY state is inserted after the last data bit
  - the parity bit is the XOR of the DATA_BITS payload bits, giving even parity
  - frame length grows by CLKS_PER_BIT cycles
- Undefined:
  - no PARITY state, no parity logic
  - frames are DATA_BITS-N-STOP_BITS

Test Plan:
- Single byte: CLK_FREQ=1000, BAUD=100 (10 cycles/bit), push 0x55 into an idle block -> o_txd falls 2 edges after accept. The line reads 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles. o_done pulses at cycle 100 of the frame, then o_busy falls.
- Back-to-back: push 0xA3, 0x0F, 0xFF on consecutive cycles -> three contiguous 100-cycle frames with no gap between them. Data reads LSB first (0xA3 -> 1,1,0,0,0,1,0,1). Exactly three o_done pulses occur.
- FIFO full/overflow: DEPTH=4; push 6 bytes on consecutive cycles with i_valid held -> bytes 1..5 are accepted (byte 1 is popped into the shift register after 1 cycle) and byte 6 is dropped. o_ready goes low on the cycle byte 6 is offered; o_overflow=1 and stays 1. Exactly 5 frames are transmitted.
- Reset mid-frame: assert i_rst during the DATA bit 3 of 0x81 with 2 bytes queued -> o_txd=1 after the reset edge; o_busy=0, o_ready=1, o_overflow=0; no further frames are sent.
- STOP_BITS=2, DATA_BITS=7: push 0x7F -> 100-cycle frame, high for the final 20 cycles; o_done on the last cycle.
- UART_TX_PARITY_EN defined: push 0x07 -> parity bit 1 after the data bits and a 110-cycle frame. Push 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB-first start/data/stop frames at CLKS_PER_BIT cycles per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_fifo #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_txd,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);

  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 push;
  logic                 pop;
  logic                 have_data;

  logic [2:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_end;
  logic                 stop_end;
  logic                 line;

  // No full-bypass: a pop on the same edge does not open a slot early.
  assign o_ready   = (count != FULL);
  assign push      = i_valid && o_ready;
  assign have_data = (count != '0);

  assign bit_end  = (baud_cnt == BIT_LAST);
  assign stop_end = (state == S_STOP) && (baud_cnt == STOP_LAST);
  assign pop      = have_data && ((state == S_IDLE) || stop_end);
  assign o_busy   = (state != S_IDLE) || have_data;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (i_valid && !o_ready) begin
        o_overflow <= 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      parity <= 1'b0;
    end else if (pop) begin
      parity <= ^mem[rd_ptr];
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (have_data) begin
            shift <= mem[rd_ptr];
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Reload straight from the FIFO so consecutive frames abut.
          if (stop_end) begin
            baud_cnt <= '0;
            if (have_data) begin
              shift <= mem[rd_ptr];
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    line = 1'b1;
    case (state)
      S_START:  line = 1'b0;
      S_DATA:   line = shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line = parity;
`endif
      default:  line = 1'b1;
    endcase
  end

  // Line and done are registered together, so o_done lines up with the last stop cycle on the wire.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_txd  <= 1'b1;
      o_done <= 1'b0;
    end else begin
      o_txd  <= line;
      o_done <= stop_end;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed test-plan steps plus random pushes, checked each cycle against a time-based line model.
// Honours UART_TX_PARITY_EN when the same macro is defined for the bench.
module tb_uart_tx_fifo;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F1 = (1 + 8 + PAR + 1) * CPB;
  localparam int F2 = (1 + 7 + PAR + 2) * CPB;

  logic       clk;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready, o_txd, o_busy, o_done, o_overflow;

  logic [6:0] i_data2;
  logic       i_valid2;
  logic       o_ready2, o_txd2, o_busy2, o_done2, o_overflow2;

  uart_tx_fifo #(
    .CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .DEPTH(DEPTH)
  ) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_txd(o_txd), .o_busy(o_busy), .o_done(o_done),
    .o_overflow(o_overflow)
  );

  uart_tx_fifo #(
    .CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .STOP_BITS(2), .DEPTH(DEPTH)
  ) u_dut2 (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data2), .i_valid(i_valid2),
    .o_ready(o_ready2), .o_txd(o_txd2), .o_busy(o_busy2), .o_done(o_done2),
    .o_overflow(o_overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int ndone = 0;

  // Model: bytes waiting in the FIFO, and frames scheduled on the line by start cycle.
  logic [7:0] mq[$];
  int         fs[$];
  logic [7:0] fb[$];
  int         tx_end = -1;
  bit         movf = 1'b0;

  function automatic logic exp_bit(input logic [7:0] b, input int nbits, input int k);
    if (k == 0) return 1'b0;
    if (k <= nbits) return b[k-1];
    if (PAR == 1 && k == nbits + 1) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bit         acc;
    logic [7:0] b;
    logic       e_txd, e_done, e_busy;
    i_valid = v;
    i_data  = d;
    i_rst   = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      mq.delete(); fs.delete(); fb.delete();
      tx_end = -1;
      movf   = 1'b0;
    end else begin
      acc = v && (mq.size() < DEPTH);
      if (v && !acc) movf = 1'b1;
      if (mq.size() > 0 && cyc >= tx_end) begin
        b = mq.pop_front();
        fs.push_back(cyc + 1);
        fb.push_back(b);
        tx_end = cyc + F1;
      end
      if (acc) mq.push_back(d);
    end
    #1;
    while (fs.size() > 0 && fs[0] + F1 <= cyc) begin
      void'(fs.pop_front());
      void'(fb.pop_front());
    end
    e_txd  = 1'b1;
    e_done = 1'b0;
    if (fs.size() > 0 && fs[0] <= cyc) begin
      e_txd  = exp_bit(fb[0], 8, (cyc - fs[0]) / CPB);
      e_done = (cyc == fs[0] + F1 - 1);
    end
    e_busy = (tx_end > cyc) || (mq.size() > 0);
    if (o_done === 1'b1) ndone++;
    chk("txd",   32'(o_txd),      32'(e_txd));
    chk("done",  32'(o_done),     32'(e_done));
    chk("busy",  32'(o_busy),     32'(e_busy));
    chk("ready", 32'(o_ready),    32'(mq.size() < DEPTH));
    chk("ovf",   32'(o_overflow), 32'(movf));
  endtask

  task automatic drain();
    int guard = 0;
    while ((mq.size() > 0 || fs.size() > 0 || tx_end >= cyc) && guard < 5000) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    repeat (3) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int         d0;
    int         burst;
    logic [6:0] b2;
    logic       v;
    i_valid2 = 1'b0;
    i_data2  = '0;

    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_txd2",   32'(o_txd2),   32'd1);
    chk("rst_busy2",  32'(o_busy2),  32'd0);
    chk("rst_ready2", 32'(o_ready2), 32'd1);
    repeat (3) step(1'b0, 8'h00, 1'b0);

    // Single byte into an idle block.
    d0 = ndone;
    step(1'b1, 8'h55, 1'b0);
    drain();
    chk("single_done_cnt", 32'(ndone - d0), 32'd1);

    // Three back-to-back pushes.
    d0 = ndone;
    step(1'b1, 8'hA3, 1'b0);
    step(1'b1, 8'h0F, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    drain();
    chk("b2b_done_cnt", 32'(ndone - d0), 32'd3);

    // Six pushes with valid held: the sixth overflows.
    d0 = ndone;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);
    drain();
    chk("ovf_done_cnt", 32'(ndone - d0), 32'd5);

    // Parity patterns (and plain frames when parity is off).
    d0 = ndone;
    step(1'b1, 8'h07, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    drain();
    chk("par_done_cnt", 32'(ndone - d0), 32'd2);

    // Reset during data bit 3 of 0x81 with two bytes queued.
    step(1'b1, 8'h81, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    repeat (42) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    d0 = ndone;
    repeat (300) step(1'b0, 8'h00, 1'b0);
    chk("rst_no_frames", 32'(ndone - d0), 32'd0);

    // 7 data bits, 2 stop bits on the second instance.
    for (int n = 0; n < 2; n++) begin
      b2 = (n == 0) ? 7'h7F : 7'($urandom);
      i_valid2 = 1'b1;
      i_data2  = b2;
      step(1'b0, 8'h00, 1'b0);
      i_valid2 = 1'b0;
      for (int c = 1; c <= F2 + 10; c++) begin
        int t;
        step(1'b0, 8'h00, 1'b0);
        t = c - 2;
        chk("txd2", 32'(o_txd2),
            32'((t >= 0 && t < F2) ? exp_bit({1'b0, b2}, 7, t / CPB) : 1'b1));
        chk("done2", 32'(o_done2), 32'(t == F2 - 1));
      end
    end

    // Random traffic with occasional bursts.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(2, 7);
      v = (burst > 0) || ($urandom_range(0, 99) < 3);
      if (burst > 0) burst--;
      step(v, 8'($urandom), 1'b0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
